cpu_system: RTL and testbench



---
 rtl/cpu_system_if.sv | 9 +
 rtl/cpu_system.sv | 168 ++++++++++++++++
 tb/tb_cpu_system.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_system_if.sv
// Memory load port of cpu_system; the loader drives it while the core is held in reset.
interface cpu_system_if;
    logic        load_we;
    logic [6:0]  load_addr;
    logic [15:0] load_data;

    modport master (output load_we, load_addr, load_data);
    modport slave  (input  load_we, load_addr, load_data);
endinterface

// File: rtl/cpu_system.sv
// 16-bit multicycle core with a private 128x16 word memory (FETCH/EXEC/MEM sequencing).
// Optional CPU_DEBUG_EN adds a combinational register-file read port.
module cpu_system (
    input  logic        clk,
    input  logic        rst_n,
    cpu_system_if.slave load,
`ifdef CPU_DEBUG_EN
    input  logic [3:0]  dbg_reg_sel,
    output logic [15:0] dbg_reg_data,
`endif
    output logic [7:0]  dbg_pc,
    output logic [2:0]  flags,
    output logic        halted
);
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpXor  = 4'h5;
    localparam logic [3:0] OpShl  = 4'h6;
    localparam logic [3:0] OpShr  = 4'h7;
    localparam logic [3:0] OpLd   = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpSt   = 4'hA;
    localparam logic [3:0] OpAddi = 4'hB;
    localparam logic [3:0] OpCmp  = 4'hC;
    localparam logic [3:0] OpHalt = 4'hE;
    localparam logic [3:0] OpLi   = 4'hF;

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalted} state_e;

    state_e      state_q;
    logic [6:0]  pc_q;
    logic [15:0] regs_q [16];
    logic [2:0]  flags_q;
    logic        halted_q;
    logic [15:0] ir_q;

    logic [15:0] mem [128];
    logic [15:0] mem_rdata_q;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;

    // The instruction is only valid on the memory output during EXEC; MEM uses the latched copy.
    logic [15:0] instr;
    logic [3:0]  op, rd, rs1, rs2;
    logic [7:0]  imm8;
    logic [15:0] rs1_val, rs2_val, rd_val;

    assign instr   = (state_q == StExec) ? mem_rdata_q : ir_q;
    assign op      = instr[15:12];
    assign rd      = instr[11:8];
    assign rs1     = instr[7:4];
    assign rs2     = instr[3:0];
    assign imm8    = instr[7:0];
    assign rs1_val = (rs1 == 4'd0) ? 16'h0 : regs_q[rs1];
    assign rs2_val = (rs2 == 4'd0) ? 16'h0 : regs_q[rs2];
    assign rd_val  = (rd == 4'd0) ? 16'h0 : regs_q[rd];

    logic [16:0] sum, diff, addi, shl, shr;
    logic [15:0] alu_res;
    logic        alu_c, alu_wr, alu_fl, jmp_taken;

    assign sum  = {1'b0, rs1_val} + {1'b0, rs2_val};
    assign diff = {1'b0, rs1_val} - {1'b0, rs2_val};
    assign addi = {1'b0, rd_val} + {1'b0, {{8{imm8[7]}}, imm8}};
    // Bit 16 of shl / bit 0 of shr hold the last bit shifted out (0 for a zero shift).
    assign shl  = {1'b0, rs1_val} << rs2_val[3:0];
    assign shr  = {rs1_val, 1'b0} >> rs2_val[3:0];

    always_comb begin
        alu_res = 16'h0;
        alu_c   = 1'b0;
        alu_wr  = 1'b0;
        alu_fl  = 1'b0;
        case (op)
            OpAdd:  begin alu_res = sum[15:0];        alu_c = sum[16];  alu_wr = 1'b1; alu_fl = 1'b1; end
            OpSub:  begin alu_res = diff[15:0];       alu_c = diff[16]; alu_wr = 1'b1; alu_fl = 1'b1; end
            OpAnd:  begin alu_res = rs1_val & rs2_val;                  alu_wr = 1'b1; alu_fl = 1'b1; end
            OpOr:   begin alu_res = rs1_val | rs2_val;                  alu_wr = 1'b1; alu_fl = 1'b1; end
            OpXor:  begin alu_res = rs1_val ^ rs2_val;                  alu_wr = 1'b1; alu_fl = 1'b1; end
            OpShl:  begin alu_res = shl[15:0];        alu_c = shl[16];  alu_wr = 1'b1; alu_fl = 1'b1; end
            OpShr:  begin alu_res = shr[16:1];        alu_c = shr[0];   alu_wr = 1'b1; alu_fl = 1'b1; end
            OpAddi: begin alu_res = addi[15:0];       alu_c = addi[16]; alu_wr = 1'b1; alu_fl = 1'b1; end
            OpCmp:  begin alu_res = diff[15:0];       alu_c = diff[16];                alu_fl = 1'b1; end
            OpLi:   begin alu_res = {8'h0, imm8};                       alu_wr = 1'b1;                 end
            default: ;
        endcase
    end

    always_comb begin
        case (rd)
            4'd0:    jmp_taken = 1'b1;
            4'd1:    jmp_taken = flags_q[0];
            4'd2:    jmp_taken = ~flags_q[0];
            4'd3:    jmp_taken = flags_q[1];
            4'd4:    jmp_taken = flags_q[2];
            default: jmp_taken = 1'b0;
        endcase
    end

    // The load port owns the memory whenever the core is in reset.
    always_comb begin
        mem_addr  = pc_q;
        mem_we    = 1'b0;
        mem_wdata = rd_val;
        if (!rst_n) begin
            mem_addr  = load.load_addr;
            mem_we    = load.load_we;
            mem_wdata = load.load_data;
        end else if (state_q == StExec && (op == OpLd || op == OpSt)) begin
            mem_addr = rs1_val[7:1];
            mem_we   = (op == OpSt);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata_q <= mem[mem_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            pc_q     <= 7'd0;
            flags_q  <= 3'b000;
            halted_q <= 1'b0;
            ir_q     <= 16'h0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 16'h0;
        end else begin
            case (state_q)
                StFetch: state_q <= StExec;
                StExec: begin
                    ir_q    <= mem_rdata_q;
                    pc_q    <= pc_q + 7'd1;
                    state_q <= StFetch;
                    if (alu_wr && rd != 4'd0) regs_q[rd] <= alu_res;
                    if (alu_fl) flags_q <= {alu_res[15], alu_c, alu_res == 16'h0};
                    case (op)
                        OpJmp: if (jmp_taken) pc_q <= imm8[7:1];
                        OpLd:  state_q <= StMem;
                        // pc stays on the HALT instruction.
                        OpHalt: begin
                            pc_q     <= pc_q;
                            state_q  <= StHalted;
                            halted_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    if (rd != 4'd0) regs_q[rd] <= mem_rdata_q;
                    state_q <= StFetch;
                end
                default: state_q <= StHalted;
            endcase
        end
    end

`ifdef CPU_DEBUG_EN
    assign dbg_reg_data = (dbg_reg_sel == 4'd0) ? 16'h0 : regs_q[dbg_reg_sel];
`endif

    assign dbg_pc = {pc_q, 1'b0};
    assign flags  = flags_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_cpu_system.sv
// Scoreboard bench for cpu_system: an instruction-level model predicts per-cycle pc/flags/halted.
module tb_cpu_system;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] dbg_pc;
    logic [2:0] flags;
    logic       halted;
`ifdef CPU_DEBUG_EN
    logic [3:0]  dbg_reg_sel = 4'd0;
    logic [15:0] dbg_reg_data;
`endif

    cpu_system_if lif ();

    cpu_system dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (lif),
`ifdef CPU_DEBUG_EN
        .dbg_reg_sel  (dbg_reg_sel),
        .dbg_reg_data (dbg_reg_data),
`endif
        .dbg_pc       (dbg_pc),
        .flags        (flags),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]        pc;
        logic [2:0]        fl;
        logic              hl;
        logic              chk;
        logic [15:0][15:0] regs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    // Reference model state
    logic [15:0] m_mem [128];
    logic [15:0] m_regs [16];
    logic [6:0]  m_pc;
    bit          m_z, m_c, m_n, m_halt;
    int          n_target, n_pushed;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rv(input logic [3:0] r);
        return (r == 4'd0) ? 16'h0 : m_regs[r];
    endfunction

    task automatic push_exp(input bit c);
        exp_t e;
        if (n_pushed >= n_target) return;
        e.pc = {m_pc, 1'b0};
        e.fl = {m_n, m_c, m_z};
        e.hl = m_halt;
        e.chk = c;
        for (int i = 0; i < 16; i++) e.regs[i] = rv(i[3:0]);
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Runs the program from reset for n cycles, one expected entry per clock edge.
    task automatic gen_trace(input int n);
        logic [15:0] ins;
        logic [3:0] op, rd, rs1, rs2;
        int unsigned a, b, d, imm, res, full, sh;
        bit wr, fl, cy, take;
        exp_q.delete();
        n_target = n; n_pushed = 0;
        m_pc = 0; m_z = 0; m_c = 0; m_n = 0; m_halt = 0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        while (n_pushed < n) begin
            if (m_halt) begin push_exp(1'b1); continue; end
            ins = m_mem[m_pc];
            push_exp(1'b0);
            if (n_pushed >= n) break;
            op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
            a = rv(rs1); b = rv(rs2); d = rv(rd); imm = ins[7:0];
            wr = 0; fl = 0; cy = 0; res = 0; sh = b % 16;
            case (op)
                4'h1: begin full = a + b; res = full % 65536; cy = full >= 65536; wr = 1; fl = 1; end
                4'h2, 4'hC: begin res = (a + 65536 - b) % 65536; cy = a < b; wr = (op == 4'h2); fl = 1; end
                4'h3: begin res = a & b; wr = 1; fl = 1; end
                4'h4: begin res = a | b; wr = 1; fl = 1; end
                4'h5: begin res = a ^ b; wr = 1; fl = 1; end
                4'h6: begin
                    res = (a << sh) % 65536; cy = (sh != 0) && (((a >> (16 - sh)) & 1) == 1);
                    wr = 1; fl = 1;
                end
                4'h7: begin
                    res = a >> sh; cy = (sh != 0) && (((a >> (sh - 1)) & 1) == 1);
                    wr = 1; fl = 1;
                end
                4'hB: begin
                    full = d + ((imm >= 128) ? imm + 65280 : imm);
                    res = full % 65536; cy = full >= 65536; wr = 1; fl = 1;
                end
                4'hF: begin res = imm; wr = 1; end
                default: ;
            endcase
            if (wr && rd != 0) m_regs[rd] = res[15:0];
            if (fl) begin m_z = (res == 0); m_n = (res >= 32768); m_c = cy; end
            if (op == 4'hA) m_mem[(a / 2) % 128] = d[15:0];
            if (op == 4'hE) begin
                m_halt = 1;
                push_exp(1'b1);
            end else if (op == 4'h9) begin
                case (rd)
                    4'd0: take = 1;
                    4'd1: take = m_z;
                    4'd2: take = !m_z;
                    4'd3: take = m_c;
                    4'd4: take = m_n;
                    default: take = 0;
                endcase
                m_pc = take ? imm[7:1] : m_pc + 7'd1;
                push_exp(1'b1);
            end else if (op == 4'h8) begin
                m_pc = m_pc + 7'd1;
                push_exp(1'b0);
                if (n_pushed >= n) break;
                if (rd != 0) m_regs[rd] = m_mem[(a / 2) % 128];
                push_exp(1'b1);
            end else begin
                m_pc = m_pc + 7'd1;
                push_exp(1'b1);
            end
        end
    endtask

    // Monitor: pops one expected entry per clock while the core runs.
    initial begin
        exp_t e;
        int bad;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_underflow: got empty queue expected an entry");
                end else begin
                    e = exp_q.pop_front();
                    chk("dbg_pc", {24'h0, dbg_pc}, {24'h0, e.pc});
                    chk("flags", {29'h0, flags}, {29'h0, e.fl});
                    chk("halted", {31'h0, halted}, {31'h0, e.hl});
                    if (e.chk) begin
                        bad = -1;
                        for (int i = 0; i < 16; i++)
                            if (dut.regs_q[i] !== e.regs[i] && bad < 0) bad = i;
                        checks++;
                        if (bad >= 0) begin
                            failures++;
                            $display("FAIL regfile r%0d: got %h expected %h", bad,
                                     dut.regs_q[bad], e.regs[bad]);
                        end
`ifdef CPU_DEBUG_EN
                        dbg_reg_sel = 4'($urandom);
                        #1;
                        chk("dbg_reg_data", {16'h0, dbg_reg_data},
                            {16'h0, e.regs[dbg_reg_sel]});
`endif
                    end
                end
            end
        end
    end

    task automatic load_mem();
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            lif.load_we = 1'b1;
            lif.load_addr = i[6:0];
            lif.load_data = m_mem[i];
        end
        @(negedge clk);
        lif.load_we = 1'b0;
    endtask

    // Loads that happen while the core runs must be ignored.
    task automatic run(input int n, input bit stray_load);
        gen_trace(n);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        if (stray_load) begin
            lif.load_we = 1'b1;
            lif.load_addr = 7'($urandom);
            lif.load_data = 16'($urandom);
        end
        repeat (n) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        lif.load_we = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic check_mem(input string nm);
        int bad = -1;
        for (int i = 0; i < 128; i++) if (dut.mem[i] !== m_mem[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s word %0d: got %h expected %h", nm, bad, dut.mem[bad], m_mem[bad]);
        end
    endtask

    task automatic set_prog(input logic [15:0] p [$]);
        for (int i = 0; i < 128; i++) m_mem[i] = (i < p.size()) ? p[i] : 16'h0000;
    endtask

    initial begin
        logic [15:0] w;
        lif.load_we = 1'b0;
        lif.load_addr = 7'd0;
        lif.load_data = 16'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_dbg_pc", {24'h0, dbg_pc}, 32'h0);
        chk("reset_flags", {29'h0, flags}, 32'h0);
        chk("reset_halted", {31'h0, halted}, 32'h0);

        // Loop: LI r1,3; LI r2,4; ADD r0,r1,r2; JMP 0
        set_prog('{16'hF103, 16'hF204, 16'h1012, 16'h9000});
        load_mem();
        run(16, 1'b0);
        chk("p1_r1", {16'h0, dut.regs_q[1]}, 32'h3);
        chk("p1_r2", {16'h0, dut.regs_q[2]}, 32'h4);
        chk("p1_r0", {16'h0, dut.regs_q[0]}, 32'h0);
        chk("p1_pc_wrapped", {24'h0, dbg_pc}, 32'h0);
        rst_n = 1'b0;

        // ADD then SUB to zero
        set_prog('{16'hF10A, 16'hF202, 16'h1312, 16'h2333, 16'hE000});
        load_mem();
        run(14, 1'b0);
        chk("p2_r3", {16'h0, dut.regs_q[3]}, 32'h0);
        chk("p2_flags", {29'h0, flags}, 32'h1);
        chk("p2_halted", {31'h0, halted}, 32'h1);
        chk("p2_pc_frozen", {24'h0, dbg_pc}, 32'h8);
        rst_n = 1'b0;

        // ST then LD of word 0x10
        set_prog('{16'hF120, 16'hF255, 16'hA210, 16'h8310, 16'hE000});
        load_mem();
        run(14, 1'b0);
        chk("p3_mem10", {16'h0, dut.mem[16]}, 32'h55);
        chk("p3_r3", {16'h0, dut.regs_q[3]}, 32'h55);
        check_mem("p3_mem");
        rst_n = 1'b0;

        // Flags: SUB to zero, CMP 0-1, untaken JMP-if-Z
        set_prog('{16'hF101, 16'h2211, 16'hC001, 16'h9100, 16'hE000});
        load_mem();
        run(14, 1'b0);
        chk("p4_flags", {29'h0, flags}, 32'h6);
        chk("p4_pc", {24'h0, dbg_pc}, 32'h8);
        rst_n = 1'b0;

        // Reset while an ADD sits in EXEC
        set_prog('{16'hF201, 16'hC002, 16'h1312, 16'hE000});
        load_mem();
        run(5, 1'b0);
        chk("p5_flags_pre", {29'h0, flags}, 32'h6);
        rst_n = 1'b0;
        #1;
        chk("p5_rst_pc", {24'h0, dbg_pc}, 32'h0);
        chk("p5_rst_flags", {29'h0, flags}, 32'h0);
        chk("p5_rst_r2", {16'h0, dut.regs_q[2]}, 32'h0);
        @(posedge clk);
        #1;
        chk("p5_rst_r3", {16'h0, dut.regs_q[3]}, 32'h0);
        run(12, 1'b0);
        check_mem("p5_mem_kept");
        rst_n = 1'b0;

        // Random programs; HALT is thinned out so runs stay busy
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 128; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'hE && $urandom_range(0, 7) != 0) w[15:12] = 4'hF;
                m_mem[i] = w;
            end
            load_mem();
            run(150, 1'b1);
            check_mem("rand_mem");
            rst_n = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
